// File: rtl/lamp_fade_if.sv
// Lamp command/status bundle between the lighting controller and the lamp fade driver.
interface lamp_fade_if #(
    parameter int PWM_BITS = 8
);
    // No valid/ready here: lamp_on and force_full are level commands sampled every clk edge,
    // and every status signal is continuously valid from reset onward.
    logic                lamp_on;
    logic                force_full;
    logic                pwm_out;
    logic [PWM_BITS-1:0] level;
    logic                busy;
    logic                at_full;
    logic                at_off;
    logic [1:0]          state_dbg;

    modport master (
        output lamp_on, force_full,
        input  pwm_out, level, busy, at_full, at_off, state_dbg
    );

    modport slave (
        input  lamp_on, force_full,
        output pwm_out, level, busy, at_full, at_off, state_dbg
    );
endinterface

// File: rtl/lamp_fade_driver.sv
// PWM lamp drive with linear soft fade-in/fade-out and an immediate full-brightness override.
module lamp_fade_driver #(
    parameter int PWM_BITS     = 8,
    parameter int STEP_PERIODS = 4
) (
    input  logic       clk,
    input  logic       rst,
    lamp_fade_if.slave bus
);
    localparam int                  STEP_W    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [PWM_BITS-1:0] MAX_LEVEL = {PWM_BITS{1'b1}};
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_PERIODS - 1);

    typedef enum logic [1:0] {
        S_OFF       = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_ON        = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    state_t              r_state;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [STEP_W-1:0]   r_step_cnt;
    logic [PWM_BITS-1:0] r_level;
    logic                r_pwm_out;

    logic                w_period_end;
    logic                w_step_tick;
    logic [PWM_BITS-1:0] w_level_up;
    logic [PWM_BITS-1:0] w_level_dn;

    assign w_period_end = (r_pwm_cnt == MAX_LEVEL);
    assign w_step_tick  = w_period_end && (r_step_cnt == STEP_LAST);

    // Saturating candidates: a ramp entered at an endpoint (e.g. ON -> RAMP_DOWN -> RAMP_UP
    // at MAX_LEVEL) must not wrap on its first tick; it simply resolves to the endpoint state.
    assign w_level_up = (w_step_tick && (r_level != MAX_LEVEL)) ? r_level + PWM_BITS'(1) : r_level;
    assign w_level_dn = (w_step_tick && (r_level != '0))        ? r_level - PWM_BITS'(1) : r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt  <= '0;
            r_step_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            if (w_period_end) begin
                r_step_cnt <= (r_step_cnt == STEP_LAST) ? '0 : r_step_cnt + STEP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_OFF;
            r_level <= '0;
        end else if (bus.force_full) begin
            r_state <= S_ON;
            r_level <= MAX_LEVEL;
        end else begin
            case (r_state)
                S_OFF: begin
                    if (bus.lamp_on) r_state <= S_RAMP_UP;
                end
                S_RAMP_UP: begin
                    r_level <= w_level_up;
                    if (w_level_up == MAX_LEVEL) r_state <= S_ON;
                    else if (!bus.lamp_on)       r_state <= S_RAMP_DOWN;
                end
                S_ON: begin
                    if (!bus.lamp_on) r_state <= S_RAMP_DOWN;
                end
                S_RAMP_DOWN: begin
                    r_level <= w_level_dn;
                    if (w_level_dn == '0)  r_state <= S_OFF;
                    else if (bus.lamp_on)  r_state <= S_RAMP_UP;
                end
                default: r_state <= S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pwm_out <= 1'b0;
        else     r_pwm_out <= (r_pwm_cnt < r_level) || (r_level == MAX_LEVEL);
    end

    assign bus.pwm_out   = r_pwm_out;
    assign bus.level     = r_level;
    assign bus.busy      = (r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN);
    assign bus.at_full   = (r_state == S_ON);
    assign bus.at_off    = (r_state == S_OFF);
    assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_lamp_fade_driver.sv
// Scenario bench for lamp_fade_driver at PWM_BITS=4, STEP_PERIODS=2 (16-cycle period, 32-cycle step).
module tb_lamp_fade_driver;
    localparam int         PWM_BITS     = 4;
    localparam int         STEP_PERIODS = 2;
    localparam logic [3:0] MAXL         = 4'd15;
    localparam logic [1:0] ST_OFF = 2'd0, ST_UP = 2'd1, ST_ON = 2'd2, ST_DN = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] m_cnt;
    logic [3:0]  exp_q[$];
    int          total = 0;
    int          bad   = 0;

    lamp_fade_if #(.PWM_BITS(PWM_BITS)) bus ();

    lamp_fade_driver #(.PWM_BITS(PWM_BITS), .STEP_PERIODS(STEP_PERIODS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Free-running cycle count since reset: [3:0] is the expected pwm_cnt, [4] the step phase.
    always @(posedge clk or posedge rst) begin
        if (rst) m_cnt <= 16'd0;
        else     m_cnt <= m_cnt + 16'd1;
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.lamp_on = 1'b0;
        bus.force_full = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_level(input logic [3:0] tgt, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (bus.level === tgt) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (bus.level === tgt) ok = 1'b1;
    endtask

    // Pops one expected level per observed level change; every change must land on a step boundary.
    task automatic track_ramp(input string name, input logic [3:0] start, input int limit,
                              output int first_i, output int last_i);
        logic [3:0] prev;
        logic [3:0] e;
        prev = start;
        first_i = -1;
        last_i = -1;
        for (int i = 0; i < limit && exp_q.size() > 0; i++) begin
            @(negedge clk);
            if (bus.level !== prev) begin
                e = exp_q.pop_front();
                total++;
                if (bus.level !== e) begin
                    bad++;
                    $display("FAIL %s_level: got %0d want %0d", name, bus.level, e);
                end
                total++;
                if (m_cnt[4:0] !== 5'd0) begin
                    bad++;
                    $display("FAIL %s_align: change at phase %0d want 0", name, m_cnt[4:0]);
                end
                if (first_i < 0) first_i = i;
                last_i = i;
                prev = bus.level;
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: %0d levels outstanding want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.lamp_on = 1'b0;
        bus.force_full = 1'b0;
        #1;
        total++; if (bus.pwm_out !== 1'b0) begin bad++; $display("FAIL reset_pwm: got %b want 0", bus.pwm_out); end
        total++; if (bus.level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.at_full !== 1'b0) begin bad++; $display("FAIL reset_at_full: got %b want 0", bus.at_full); end
        total++; if (bus.at_off !== 1'b1) begin bad++; $display("FAIL reset_at_off: got %b want 1", bus.at_off); end
        total++; if (bus.state_dbg !== ST_OFF) begin bad++; $display("FAIL reset_state: got %0d want %0d", bus.state_dbg, ST_OFF); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        bit ok;
        do_reset();
        bus.lamp_on = 1'b1;
        wait_level(4'd6, 300, ok);
        total++; if (!ok || bus.busy !== 1'b1) begin bad++; $display("FAIL midrst_reach6: level %0d busy %b want 6 1", bus.level, bus.busy); end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.level !== 4'd0) begin bad++; $display("FAIL midrst_level: got %0d want 0", bus.level); end
        total++; if (bus.pwm_out !== 1'b0) begin bad++; $display("FAIL midrst_pwm: got %b want 0", bus.pwm_out); end
        total++; if (bus.at_off !== 1'b1) begin bad++; $display("FAIL midrst_at_off: got %b want 1", bus.at_off); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        bus.lamp_on = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fade_in();
        int first_i, last_i, lows;
        do_reset();
        bus.lamp_on = 1'b1;
        @(negedge clk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL fadein_busy: got %b want 1", bus.busy); end
        total++; if (bus.state_dbg !== ST_UP) begin bad++; $display("FAIL fadein_state: got %0d want %0d", bus.state_dbg, ST_UP); end
        for (int l = 1; l <= 15; l++) exp_q.push_back(4'(l));
        track_ramp("fadein", 4'd0, 600, first_i, last_i);
        total++; if (last_i - first_i != 14 * 32) begin bad++; $display("FAIL fadein_duration: got %0d want %0d", last_i - first_i, 14 * 32); end
        total++; if (bus.at_full !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL fadein_status: at_full %b busy %b want 1 0", bus.at_full, bus.busy); end
        @(negedge clk);
        lows = 0;
        for (int i = 0; i < 32; i++) begin
            if (bus.pwm_out !== 1'b1) lows++;
            @(negedge clk);
        end
        total++; if (lows != 0) begin bad++; $display("FAIL fadein_pwm_full: got %0d low cycles want 0", lows); end
    endtask

    task automatic test_duty();
        bit ok;
        int highs;
        logic [15:0] pc;
        logic [3:0] e;
        do_reset();
        bus.lamp_on = 1'b1;
        wait_level(4'd4, 200, ok);
        total++; if (!ok) begin bad++; $display("FAIL duty_reach4: got %0d want 4", bus.level); end
        highs = 0;
        for (int i = 0; i < 32; i++) begin
            pc = m_cnt - 16'd1;
            exp_q.push_back((pc[3:0] < 4'd4) ? 4'd1 : 4'd0);
            e = exp_q.pop_front();
            total++;
            if ({3'b000, bus.pwm_out} !== e) begin
                bad++;
                $display("FAIL duty_cycle: pwm %b at cnt %0d want %0d", bus.pwm_out, pc[3:0], e);
            end
            if (bus.pwm_out === 1'b1) highs++;
            @(negedge clk);
        end
        total++; if (highs != 8) begin bad++; $display("FAIL duty_count: got %0d high of 32 want 8", highs); end
    endtask

    task automatic test_reversal();
        bit ok;
        int first_i, last_i, highs;
        do_reset();
        bus.lamp_on = 1'b1;
        wait_level(4'd7, 300, ok);
        total++; if (!ok || bus.state_dbg !== ST_UP) begin bad++; $display("FAIL rev_reach7: level %0d state %0d want 7 %0d", bus.level, bus.state_dbg, ST_UP); end
        bus.lamp_on = 1'b0;
        @(negedge clk);
        total++; if (bus.state_dbg !== ST_DN || bus.level !== 4'd7) begin bad++; $display("FAIL rev_turn: state %0d level %0d want %0d 7", bus.state_dbg, bus.level, ST_DN); end
        for (int l = 6; l >= 0; l--) exp_q.push_back(4'(l));
        track_ramp("rev", 4'd7, 300, first_i, last_i);
        total++; if (bus.at_off !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL rev_status: at_off %b busy %b want 1 0", bus.at_off, bus.busy); end
        highs = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bus.pwm_out !== 1'b0) highs++;
        end
        total++; if (highs != 0) begin bad++; $display("FAIL rev_pwm_off: got %0d high cycles want 0", highs); end
    endtask

    task automatic test_override();
        int first_i, last_i, drift;
        do_reset();
        bus.force_full = 1'b1;
        @(negedge clk);
        total++; if (bus.level !== MAXL) begin bad++; $display("FAIL ovr_level: got %0d want 15", bus.level); end
        total++; if (bus.at_full !== 1'b1 || bus.state_dbg !== ST_ON) begin bad++; $display("FAIL ovr_state: at_full %b state %0d want 1 %0d", bus.at_full, bus.state_dbg, ST_ON); end
        @(negedge clk);
        total++; if (bus.pwm_out !== 1'b1) begin bad++; $display("FAIL ovr_pwm: got %b want 1", bus.pwm_out); end
        drift = 0;
        for (int i = 0; i < 24; i++) begin
            bus.lamp_on = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.level !== MAXL || bus.at_full !== 1'b1 || bus.pwm_out !== 1'b1) drift++;
        end
        total++; if (drift != 0) begin bad++; $display("FAIL ovr_hold: got %0d disturbed cycles want 0", drift); end
        bus.force_full = 1'b0;
        bus.lamp_on = 1'b0;
        @(negedge clk);
        total++; if (bus.state_dbg !== ST_DN || bus.busy !== 1'b1) begin bad++; $display("FAIL ovr_release: state %0d busy %b want %0d 1", bus.state_dbg, bus.busy, ST_DN); end
        for (int l = 14; l >= 0; l--) exp_q.push_back(4'(l));
        track_ramp("ovr_down", MAXL, 600, first_i, last_i);
        total++; if (bus.at_off !== 1'b1) begin bad++; $display("FAIL ovr_at_off: got %b want 1", bus.at_off); end
    endtask

    task automatic test_collision();
        bit ok;
        do_reset();
        bus.lamp_on = 1'b1;
        wait_level(4'd14, 600, ok);
        total++; if (!ok) begin bad++; $display("FAIL coll_reach14: got %0d want 14", bus.level); end
        for (int i = 0; i < 40 && m_cnt[4:0] !== 5'd31; i++) @(negedge clk);
        bus.lamp_on = 1'b0;
        @(negedge clk);
        total++; if (bus.level !== MAXL || bus.at_full !== 1'b1) begin bad++; $display("FAIL coll_hit_full: level %0d at_full %b want 15 1", bus.level, bus.at_full); end
        @(negedge clk);
        total++; if (bus.state_dbg !== ST_DN || bus.busy !== 1'b1 || bus.at_full !== 1'b0) begin bad++; $display("FAIL coll_one_cycle_on: state %0d busy %b at_full %b want %0d 1 0", bus.state_dbg, bus.busy, bus.at_full, ST_DN); end
        total++; if (bus.level !== MAXL) begin bad++; $display("FAIL coll_level_hold: got %0d want 15", bus.level); end
    endtask

    initial begin
        bus.lamp_on = 1'b0;
        bus.force_full = 1'b0;
        test_reset();
        test_mid_reset();
        test_fade_in();
        test_duty();
        test_reversal();
        test_override();
        test_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
